pipe_add: RTL
=============

PIPE_ADD -- requirements
Module: pipe_add

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter SLICE, default 8: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SLICE; derived NSLICE = WIDTH/SLICE.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-006 in_ready  output  1  pipeline accepts an operand set this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in; used only when sub=0.
REQ-009 sub  input  1  0: s=a+b+cin; 1: s=a-b, computed as a+~b+1 with cin ignored.
REQ-010 out_valid  output  1  result present on s, cout, ovf.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 s  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-015 The block SHALL be an NSLICE-stage pipeline; stage k adds bits [k*SLICE+SLICE-1 : k*SLICE] using the carry registered by stage k-1.
REQ-016 Stage 0 SHALL take carry-in = sub ? 1 : cin, and SHALL use b XOR {WIDTH{sub}} as its B operand.
REQ-017 Operand bits not yet consumed SHALL travel down the pipeline with their transaction; finished sum slices SHALL travel with it too, so no two transactions mix.
REQ-018 Latency SHALL be exactly NSLICE cycles from an accepted input (in_valid & in_ready at an edge) to out_valid, when no stall occurs.
REQ-019 Throughput SHALL be one transaction per cycle when out_ready stays high.
REQ-020 Each stage SHALL hold a valid bit; empty stages are bubbles and carry no result.
REQ-021 Stall SHALL equal out_valid & ~out_ready; during a stall all stages, including valid bits, hold their values.
REQ-022 in_ready SHALL equal ~stall, combinationally.
REQ-023 Outputs s, cout, ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, computed in the last stage.
REQ-025 When out_valid=0, s, cout, and ovf SHALL hold their last values; the bench does not check them.
REQ-026 When in_valid=0 and stall=0, a bubble SHALL enter stage 0.
REQ-027 Transactions SHALL exit in acceptance order, and none SHALL be dropped or duplicated.
REQ-028 SLICE=WIDTH SHALL be legal and give a single-stage adder with latency 1.

Reset
REQ-029 While rst_n=0, all stage valid bits, out_valid, s, cout, and ovf SHALL be 0, immediately and independently of clk.
REQ-030 In-flight transactions SHALL be discarded on reset, and none SHALL appear after reset is released.
REQ-031 After rst_n rises, in_ready SHALL be 1 and the first accepted input SHALL emerge NSLICE cycles later.

Structure
REQ-032 A shared header pipe_add_defs.v SHALL hold the default WIDTH and SLICE values and the NSLICE derivation, using include guards.
REQ-033 A sub-module add_slice SHALL be the combinational SLICE-bit adder (a, b, cin -> s, cout, plus carry into the MSB for the ovf calculation); pipe_add SHALL instantiate NSLICE copies via generate.
REQ-034 All registers SHALL reside in pipe_add; add_slice SHALL have no state.

Verification
REQ-035 Defaults: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles s=0x00000000, cout=1, ovf=0.
REQ-036 Defaults: a=0x7FFFFFFF, b=0x00000001, sub=0 -> s=0x80000000, cout=0, ovf=1; then a=0x00000005, b=0x00000007, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0.
REQ-037 Back-to-back stream of 16 random transactions with out_ready=1 -> 16 results on 16 consecutive cycles starting at cycle 4, each matching a reference model, in order.
REQ-038 Stream of 8 transactions with out_ready toggled pseudo-randomly -> in_ready low exactly when stalled, outputs stable during stall, all 8 results correct and in order.
REQ-039 rst_n pulsed low asynchronously, mid-cycle, with 3 transactions in flight -> out_valid drops at once, nothing emerges afterward, and the next input emerges 4 cycles after acceptance.
REQ-040 WIDTH=16, SLICE=16: a=0x8000, b=0x8000, sub=0 -> after 1 cycle s=0x0000, cout=1, ovf=1.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Package for the pipelined adder: default geometry taken from the shared
// header, plus the stage-count helper used by the top.
`include "pipe_add_defs.v"

package pipe_add_pkg;

  localparam int DEF_WIDTH = `PIPE_ADD_WIDTH;
  localparam int DEF_SLICE = `PIPE_ADD_SLICE;

  function automatic int nslice(input int width, input int slice);
    return `PIPE_ADD_NSLICE(width, slice);
  endfunction

endpackage

// File: rtl/add_slice.sv
// Stateless SLICE-bit ripple adder; also reports the carry into its MSB so the
// last stage can form the signed-overflow flag.
module add_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [SLICE:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, cin_i};
  assign s_o    = full[SLICE-1:0];
  assign cout_o = full[SLICE];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
  assign cmsb_o = a_i[SLICE-1] ^ b_i[SLICE-1] ^ full[SLICE-1];

endmodule

// File: rtl/pipe_add_defs.v
// Shared build-time defaults for the pipelined adder: operand width, slice
// width and the derived stage count.
`ifndef PIPE_ADD_DEFS_V
`define PIPE_ADD_DEFS_V

`define PIPE_ADD_WIDTH 32
`define PIPE_ADD_SLICE 8
`define PIPE_ADD_NSLICE(w, s) ((w) / (s))

`endif

// File: rtl/pipe_add.sv
// NSLICE-stage pipelined add/subtract: each stage adds one SLICE-bit slice with
// the carry registered by the stage before it.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high, on each side. The pipe stalls only when the last stage holds a result
// that downstream refuses (out_valid & ~out_ready); then every stage freezes
// and in_ready drops in the same cycle. Once valid is raised the producer
// keeps its payload steady until the transfer.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = nslice(WIDTH, SLICE);

  // res_q holds the operand A with its low slices already replaced by sum bits.
  logic             valid_q [NSLICE];
  logic [WIDTH-1:0] res_q   [NSLICE];
  logic [WIDTH-1:0] b_q     [NSLICE];
  logic             carry_q [NSLICE];
  logic             ovf_q;

  logic             v_in    [NSLICE];
  logic [WIDTH-1:0] r_in    [NSLICE];
  logic [WIDTH-1:0] b_in    [NSLICE];
  logic             c_in    [NSLICE];
  logic [SLICE-1:0] slice_s [NSLICE];
  logic             carry_d [NSLICE];
  logic             cmsb_w  [NSLICE];
  logic [WIDTH-1:0] res_d   [NSLICE];

  logic stall;

  assign stall    = valid_q[NSLICE-1] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}}) << (k * SLICE);

    if (k == 0) begin : g_src
      assign v_in[k] = in_valid;
      assign r_in[k] = a;
      assign b_in[k] = b ^ {WIDTH{sub}};
      assign c_in[k] = sub | cin;
    end else begin : g_src
      assign v_in[k] = valid_q[k-1];
      assign r_in[k] = res_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = carry_q[k-1];
    end

    add_slice #(.SLICE(SLICE)) u_slice (
      .a_i    (r_in[k][k*SLICE +: SLICE]),
      .b_i    (b_in[k][k*SLICE +: SLICE]),
      .cin_i  (c_in[k]),
      .s_o    (slice_s[k]),
      .cout_o (carry_d[k]),
      .cmsb_o (cmsb_w[k])
    );

    assign res_d[k] = (r_in[k] & ~MASK) | (WIDTH'(slice_s[k]) << (k * SLICE));
  end

  // Payload registers load only behind a valid bit, so bubbles never disturb
  // the last result presented on s/cout/ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLICE; k++) begin
        valid_q[k] <= 1'b0;
        res_q[k]   <= '0;
        b_q[k]     <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NSLICE; k++) begin
        valid_q[k] <= v_in[k];
        if (v_in[k]) begin
          res_q[k]   <= res_d[k];
          b_q[k]     <= b_in[k];
          carry_q[k] <= carry_d[k];
        end
      end
      if (v_in[NSLICE-1]) begin
        ovf_q <= cmsb_w[NSLICE-1] ^ carry_d[NSLICE-1];
      end
    end
  end

  assign out_valid = valid_q[NSLICE-1];
  assign s         = res_q[NSLICE-1];
  assign cout      = carry_q[NSLICE-1];
  assign ovf       = ovf_q;

endmodule
